// File: rtl/l1_fill_ctrl.sv
// Miss/fill controller for the L1 direct-mapped data cache: fetches a line word by word on a read miss
// and forwards every store to memory. Define CRITICAL_WORD_FIRST_EN to start the fill at the missed word.
module l1_fill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic                  cache_hit,
  output logic                  cpu_stall,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_mark_valid,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_ready,
  input  logic                  ram_rsp_valid,
  input  logic [DATA_WIDTH-1:0] ram_rsp_data
);
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int WORDS_PER_LINE = LINE_SIZE / BYTES_PER_WORD;
  localparam int WORD_OFF       = $clog2(BYTES_PER_WORD);
  localparam int LINE_OFF       = $clog2(LINE_SIZE);
  localparam int BEAT_W         = LINE_OFF - WORD_OFF;

  typedef enum logic [2:0] {IDLE, WRITE, FILL_REQ, FILL_WAIT, DONE} state_t;

  state_t                r_state, w_next;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_fill_en, r_fill_mark;
  logic [ADDR_WIDTH-1:0] r_fill_addr;
  logic [DATA_WIDTH-1:0] r_fill_data;
  logic [BEAT_W-1:0]     w_word_idx;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [ADDR_WIDTH-1:0] w_line_base;
  logic                  w_last;
  logic                  w_stall, w_req, w_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [BEAT_W-1:0] r_crit;
  // Wraps modulo the line so the fetch order rotates from the missed word.
  assign w_word_idx = r_crit + r_beat;
`else
  assign w_word_idx = r_beat;
`endif

  // r_addr holds the line base during a fill, so offset bits are zero and OR-in acts as add.
  assign w_word_addr = {r_addr[ADDR_WIDTH-1:LINE_OFF], w_word_idx, {WORD_OFF{1'b0}}};
  assign w_line_base = {mem_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign w_last      = (r_beat == BEAT_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fill_en   <= 1'b0;
      r_fill_mark <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      r_crit      <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_fill_en   <= 1'b0;
      r_fill_mark <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_valid && mem_we) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_w_data;
          end else if (mem_valid && !cache_hit) begin
            r_addr <= w_line_base;
            r_beat <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_crit <= mem_addr[LINE_OFF-1:WORD_OFF];
`endif
          end
        end
        FILL_WAIT: begin
          if (ram_rsp_valid) begin
            r_fill_en   <= 1'b1;
            r_fill_data <= ram_rsp_data;
            r_fill_addr <= w_word_addr;
            r_fill_mark <= w_last;
            if (!w_last) r_beat <= r_beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_ram_addr = r_addr;
    case (r_state)
      IDLE: begin
        if (mem_valid && mem_we) begin
          w_stall = 1'b1;
          w_next  = WRITE;
        end else if (mem_valid && !cache_hit) begin
          w_stall = 1'b1;
          w_next  = FILL_REQ;
        end
      end
      WRITE: begin
        // Released in the accept cycle so the CPU advances on the same edge.
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_stall = !ram_ready;
        if (ram_ready) w_next = IDLE;
      end
      FILL_REQ: begin
        w_req      = 1'b1;
        w_stall    = 1'b1;
        w_ram_addr = w_word_addr;
        if (ram_ready) w_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        w_stall = 1'b1;
        if (ram_rsp_valid) w_next = w_last ? DONE : FILL_REQ;
      end
      DONE: begin
        w_stall = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign cpu_stall       = w_stall;
  assign ram_req         = w_req;
  assign ram_we          = w_we;
  assign ram_addr        = w_ram_addr;
  assign ram_wdata       = r_wdata;
  assign fill_en         = r_fill_en;
  assign fill_addr       = r_fill_addr;
  assign fill_data       = r_fill_data;
  assign fill_mark_valid = r_fill_mark;

endmodule
